nic_access_sched: RTL and testbench
===================================

NIC_ACCESS_SCHED -- requirements
Module: nic_access_sched

Interface
REQ-001 Parameter: MAX_POLL, default 4, number of status-register polls per request before it completes with failure (1..15).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester request pending (bit i = requester i).
REQ-005 req_wr  input  2  per-requester op: 1 = send (to output channel), 0 = receive (from input channel).
REQ-006 req_wdata0, req_wdata1  input  64 each  send payload for requester 0 / 1.
REQ-007 req_ready  output  2  one-cycle pulse: request i accepted.
REQ-008 req_done  output  2  one-cycle pulse: request i finished.
REQ-009 req_ok  output  1  valid with req_done: 1 = transfer done, 0 = poll limit hit.
REQ-010 req_rdata  output  64  valid with req_done on a successful receive, else 0.
REQ-011 nicEn  output  1  NIC processor-port enable.
REQ-012 nicWrEn  output  1  NIC write enable (1 = write, 0 = read).
REQ-013 addr  output  2  NIC register: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
REQ-014 d_in  output  64  write data to NIC.
REQ-015 d_out  input  64  read data from NIC, valid combinationally while nicEn=1, nicWrEn=0; status in bit 0.

Function
REQ-016 FSM states: IDLE, POLL, XFER, DONE; Moore outputs decoded from the state register and latched request.
REQ-017 IDLE: if any req_valid bit is 1, grant one requester, pulse its req_ready, latch op, index and payload, clear poll counter, go to POLL on the same edge.
REQ-018 Arbitration round-robin: a 1-bit pointer names the preferred requester; if both valid, the preferred one wins; pointer flips to the other requester when a request reaches DONE.
REQ-019 A single valid request is granted regardless of the pointer.
REQ-020 Payload latched at grant; requester may change req_wdata and req_valid after the req_ready cycle.
REQ-021 req_valid dropped before grant is a silent withdrawal: no ready, no done.
REQ-022 POLL: nicEn=1, nicWrEn=0, addr=11 (send) or 01 (receive); d_out[0] sampled at the edge.
REQ-023 POLL advance condition: send needs d_out[0]=0 (output buffer empty); receive needs d_out[0]=1 (input buffer full); when met, go to XFER.
REQ-024 Otherwise, increment the poll counter; on reaching MAX_POLL, go to DONE with ok=0; below MAX_POLL, stay in POLL.
REQ-025 XFER send: nicEn=1, nicWrEn=1, addr=10, d_in=latched payload, for exactly one cycle, then DONE with ok=1.
REQ-026 XFER receive: nicEn=1, nicWrEn=0, addr=00; d_out captured into rdata register at the edge, then DONE with ok=1.
REQ-027 DONE: req_done[i]=1, req_ok, req_rdata driven for one cycle; then IDLE, where a new grant is possible the following cycle.
REQ-028 Outside POLL/XFER: nicEn=0, nicWrEn=0, addr=00, d_in=0.
REQ-029 Best-case latency: grant edge -> POLL cycle -> XFER cycle -> DONE cycle; req_done 3 cycles after the req_ready cycle.
REQ-030 Requests arriving while busy stay pending; at most one NIC access is in flight.
REQ-031 req_ready and req_done are never asserted together, and never for both requesters in the same cycle.

Reset
REQ-032 reset=1 forces IDLE, pointer=0 (requester 0 preferred), poll counter=0, rdata=0, all outputs 0, immediately without a clock.
REQ-033 Reset mid-operation aborts the in-flight request with no req_done; a NIC write in progress is dropped.
REQ-034 After deassertion, the first grant occurs on the first edge with req_valid nonzero.

Verification
REQ-035 Send: req_valid=01, req_wr=01, wdata0=1204, d_out[0]=0 -> ready[0]; POLL addr=11; XFER addr=10 nicWrEn=1 d_in=1204; done[0] ok=1, 3 cycles after ready.
REQ-036 Receive: req_valid=10, req_wr=00, d_out[0]=1 then d_out=1312 -> POLL addr=01; XFER addr=00; done[1] ok=1 rdata=1312.
REQ-037 Poll timeout: send with d_out[0] held 1, MAX_POLL=4 -> 4 POLL cycles, no write strobe, done ok=0 rdata=0.
REQ-038 Contention: req_valid=11 held after reset -> grant order 0,1,0,1; each req_done precedes the next req_ready.
REQ-039 Reset asserted during XFER -> all outputs 0 at once, no req_done; next request after release completes normally.
REQ-040 Withdrawal: req_valid[0] pulsed for 1 cycle while busy with requester 1 -> no ready[0] and no done[0] afterwards.

Source files
------------

// File: rtl/nic_access_sched_if.sv
// -----------------------------------------------------------------------------
// nic_access_sched_if
// Bundles the two-requester handshake and the NIC processor-port signals used
// by nic_access_sched.
//   slave  : the scheduler side (drives req_ready/req_done/req_ok/req_rdata and
//            the NIC strobes nicEn/nicWrEn/addr/d_in; receives requests and d_out)
//   master : the environment side (requesters plus the NIC read-data return)
// -----------------------------------------------------------------------------
interface nic_access_sched_if;
   logic [1:0]  req_valid;
   logic [1:0]  req_wr;
   logic [63:0] req_wdata0;
   logic [63:0] req_wdata1;
   logic [1:0]  req_ready;
   logic [1:0]  req_done;
   logic        req_ok;
   logic [63:0] req_rdata;
   logic        nicEn;
   logic        nicWrEn;
   logic [1:0]  addr;
   logic [63:0] d_in;
   logic [63:0] d_out;

   modport slave (
      input  req_valid, req_wr, req_wdata0, req_wdata1, d_out,
      output req_ready, req_done, req_ok, req_rdata, nicEn, nicWrEn, addr, d_in
   );

   modport master (
      output req_valid, req_wr, req_wdata0, req_wdata1, d_out,
      input  req_ready, req_done, req_ok, req_rdata, nicEn, nicWrEn, addr, d_in
   );
endinterface

// File: rtl/nic_access_sched.sv
// -----------------------------------------------------------------------------
// nic_access_sched
// Round-robin scheduler giving two requesters serialized access to a NIC
// processor port. Each request polls the relevant status register up to
// MAX_POLL times, then performs one buffer write (send) or read (receive).
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : nic_access_sched_if.slave (request handshake + NIC port)
// Parameter:
//   MAX_POLL : status polls per request before failing (1..15)
// -----------------------------------------------------------------------------
module nic_access_sched #(
   parameter int unsigned MAX_POLL = 4
) (
   input logic               clk,
   input logic               reset,
   nic_access_sched_if.slave bus
);

   localparam logic [3:0] POLL_LIMIT = 4'(MAX_POLL);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_POLL,
      ST_XFER,
      ST_DONE
   } state_t;

   state_t      state_q;
   logic        ptr_q;       // preferred requester when both are valid
   logic        idx_q;       // granted requester
   logic        op_q;        // 1 = send, 0 = receive
   logic [63:0] payload_q;
   logic [3:0]  poll_cnt_q;
   logic [3:0]  poll_cnt_d;

   // Registered outputs
   logic [1:0]  done_q;
   logic        ok_q;
   logic [63:0] rdata_q;
   logic        nic_en_q;
   logic        nic_wr_q;
   logic [1:0]  addr_q;
   logic [63:0] d_in_q;

   logic grant0;
   logic grant1;
   logic grant_any;
   logic status_met;

   always_comb begin
      grant0     = bus.req_valid[0] & (~bus.req_valid[1] | ~ptr_q);
      grant1     = bus.req_valid[1] & (~bus.req_valid[0] |  ptr_q);
      // Gated by reset so req_ready is zero immediately while reset is held.
      grant_any  = (state_q == ST_IDLE) & ~reset & (grant0 | grant1);
      // Send waits for an empty output buffer, receive for a full input buffer.
      status_met = op_q ? ~bus.d_out[0] : bus.d_out[0];
      poll_cnt_d = poll_cnt_q + 4'd1;
   end

   // req_ready is the only Mealy output: it pulses in the IDLE cycle that
   // sees the request, so the grant edge is the edge that enters POLL.
   assign bus.req_ready = grant_any ? {grant1, grant0} : 2'b00;
   assign bus.req_done  = done_q;
   assign bus.req_ok    = ok_q;
   assign bus.req_rdata = rdata_q;
   assign bus.nicEn     = nic_en_q;
   assign bus.nicWrEn   = nic_wr_q;
   assign bus.addr      = addr_q;
   assign bus.d_in      = d_in_q;

   // Output registers are loaded with the values belonging to the state being
   // entered, so they behave as Moore outputs of state_q without a decode stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ptr_q      <= 1'b0;
         idx_q      <= 1'b0;
         op_q       <= 1'b0;
         payload_q  <= '0;
         poll_cnt_q <= '0;
         done_q     <= '0;
         ok_q       <= 1'b0;
         rdata_q    <= '0;
         nic_en_q   <= 1'b0;
         nic_wr_q   <= 1'b0;
         addr_q     <= '0;
         d_in_q     <= '0;
      end else begin
         done_q   <= '0;
         ok_q     <= 1'b0;
         rdata_q  <= '0;
         nic_en_q <= 1'b0;
         nic_wr_q <= 1'b0;
         addr_q   <= '0;
         d_in_q   <= '0;

         case (state_q)
            ST_IDLE: begin
               if (grant_any) begin
                  idx_q      <= grant1;
                  op_q       <= grant1 ? bus.req_wr[1] : bus.req_wr[0];
                  payload_q  <= grant1 ? bus.req_wdata1 : bus.req_wdata0;
                  poll_cnt_q <= '0;
                  state_q    <= ST_POLL;
                  nic_en_q   <= 1'b1;
                  addr_q     <= (grant1 ? bus.req_wr[1] : bus.req_wr[0]) ? 2'b11 : 2'b01;
               end
            end

            ST_POLL: begin
               if (status_met) begin
                  state_q  <= ST_XFER;
                  nic_en_q <= 1'b1;
                  nic_wr_q <= op_q;
                  addr_q   <= op_q ? 2'b10 : 2'b00;
                  d_in_q   <= op_q ? payload_q : '0;
               end else if (poll_cnt_d == POLL_LIMIT) begin
                  poll_cnt_q <= poll_cnt_d;
                  state_q    <= ST_DONE;
                  done_q     <= idx_q ? 2'b10 : 2'b01;
                  ok_q       <= 1'b0;
                  ptr_q      <= ~idx_q;
               end else begin
                  poll_cnt_q <= poll_cnt_d;
                  nic_en_q   <= 1'b1;
                  addr_q     <= op_q ? 2'b11 : 2'b01;
               end
            end

            ST_XFER: begin
               state_q <= ST_DONE;
               done_q  <= idx_q ? 2'b10 : 2'b01;
               ok_q    <= 1'b1;
               rdata_q <= op_q ? '0 : bus.d_out;
               ptr_q   <= ~idx_q;
            end

            ST_DONE: begin
               state_q <= ST_IDLE;
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nic_access_sched.sv
module tb_nic_access_sched;

   localparam int unsigned MAX_POLL = 4;
   localparam logic [63:0] JUNK     = 64'hDEAD_BEEF_CAFE_F00D;
   localparam logic [62:0] JUNK_HI  = 63'h5A5A_5A5A_5A5A_5A5A;

   logic clk = 1'b0;
   logic reset;

   nic_access_sched_if bus();

   nic_access_sched #(.MAX_POLL(MAX_POLL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // NIC model: status bits in bit 0 with junk above, junk when not reading.
   logic        out_busy;
   logic        in_full;
   logic [63:0] in_data;

   assign bus.d_out = (bus.nicEn && !bus.nicWrEn) ?
                      ((bus.addr == 2'b00) ? in_data :
                       (bus.addr == 2'b01) ? {JUNK_HI, in_full} :
                       (bus.addr == 2'b11) ? {JUNK_HI, out_busy} : JUNK) : JUNK;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      bit          idx;
      bit          wr;
      logic [63:0] wdata;
      bit          ok;
      logic [63:0] rdata;
      int          lat;
      int          polls;
      int          writes;
      int          reads;
   } exp_t;

   exp_t sb[$];
   int   grant_log[$];
   int   cyc = 0;
   int   rdy_cyc = 0;
   int   n_polls = 0;
   int   n_writes = 0;
   int   n_reads = 0;
   int   rdy_cnt[2];
   int   done_cnt[2];
   bit   ptr_m = 1'b0;

   // Monitor / scoreboard, sampling at the falling edge.
   always @(negedge clk) begin
      logic [1:0] rdy;
      logic [1:0] dn;
      bit         exp_idx;
      bit         i;
      exp_t       e;
      cyc++;
      if (!reset) begin
         rdy = bus.req_ready;
         dn  = bus.req_done;
         check("excl", 128'(((|rdy) && (|dn)) || rdy == 2'b11 || dn == 2'b11), 128'(0));
         if (!bus.nicEn)
            check("idle_bus", 128'({bus.nicWrEn, bus.addr, bus.d_in}), 128'(0));
         if (|rdy) begin
            exp_idx = (bus.req_valid == 2'b11) ? ptr_m : bus.req_valid[1];
            check("grant_idx", 128'(rdy), 128'(exp_idx ? 2'b10 : 2'b01));
            check("one_in_flight", 128'(sb.size()), 128'(0));
            i        = rdy[1];
            e.idx    = i;
            e.wr     = bus.req_wr[i];
            e.wdata  = i ? bus.req_wdata1 : bus.req_wdata0;
            e.ok     = e.wr ? !out_busy : in_full;
            e.rdata  = (!e.wr && e.ok) ? in_data : 64'd0;
            e.lat    = e.ok ? 3 : MAX_POLL + 1;
            e.polls  = e.ok ? 1 : MAX_POLL;
            e.writes = (e.ok && e.wr) ? 1 : 0;
            e.reads  = (e.ok && !e.wr) ? 1 : 0;
            sb.push_back(e);
            rdy_cyc  = cyc;
            n_polls  = 0;
            n_writes = 0;
            n_reads  = 0;
            rdy_cnt[i]++;
            grant_log.push_back(int'(i));
         end
         if (bus.nicEn) begin
            if (sb.size() == 0) begin
               check("stray_access", 128'(bus.nicEn), 128'(0));
            end else if (bus.nicWrEn) begin
               n_writes++;
               check("wr_addr", 128'(bus.addr), 128'(2'b10));
               check("wr_data", 128'(bus.d_in), 128'(sb[0].wdata));
            end else if (bus.addr == (sb[0].wr ? 2'b11 : 2'b01)) begin
               n_polls++;
            end else if (bus.addr == 2'b00 && !sb[0].wr) begin
               n_reads++;
            end else begin
               check("rd_addr", 128'(bus.addr), 128'(sb[0].wr ? 2'b11 : 2'b01));
            end
         end
         if (|dn) begin
            done_cnt[dn[1]]++;
            if (sb.size() == 0) begin
               check("unexpected_done", 128'(dn), 128'(0));
            end else begin
               e = sb.pop_front();
               check("done_idx", 128'(dn), 128'(e.idx ? 2'b10 : 2'b01));
               check("done_ok", 128'(bus.req_ok), 128'(e.ok));
               check("done_rdata", 128'(bus.req_rdata), 128'(e.rdata));
               check("done_lat", 128'(cyc - rdy_cyc), 128'(e.lat));
               check("poll_count", 128'(n_polls), 128'(e.polls));
               check("write_count", 128'(n_writes), 128'(e.writes));
               check("read_count", 128'(n_reads), 128'(e.reads));
               ptr_m = !e.idx;
            end
         end else begin
            check("rsp_idle", 128'({bus.req_ok, bus.req_rdata}), 128'(0));
         end
      end
   end

   task automatic set_wdata(input bit i, input logic [63:0] wd);
      if (i) bus.req_wdata1 = wd;
      else   bus.req_wdata0 = wd;
   endtask

   task automatic wait_ready(input bit i, input int r0);
      int w;
      w = 0;
      do begin
         @(posedge clk); #1;
         w++;
      end while (rdy_cnt[i] == r0 && w < 20);
      check("ready_lat", 128'(w), 128'(1));
   endtask

   task automatic wait_done(input bit i, input int d0);
      int w;
      w = 0;
      while (done_cnt[i] == d0 && w < 40) begin
         @(posedge clk); #1;
         w++;
      end
      check("done_seen", 128'(done_cnt[i] - d0), 128'(1));
   endtask

   task automatic do_req(input bit i, input bit wr, input logic [63:0] wd);
      int r0;
      int d0;
      r0 = rdy_cnt[i];
      d0 = done_cnt[i];
      bus.req_wr[i] = wr;
      set_wdata(i, wd);
      bus.req_valid[i] = 1'b1;
      wait_ready(i, r0);
      bus.req_valid[i] = 1'b0;
      set_wdata(i, ~wd);   // payload must already be latched
      wait_done(i, d0);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      #1;
      check("rst_ctrl", 128'({bus.req_ready, bus.req_done, bus.req_ok, bus.nicEn, bus.nicWrEn, bus.addr}), 128'(0));
      check("rst_data", 128'({bus.req_rdata, bus.d_in}), 128'(0));
      sb.delete();
      ptr_m = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      int r0;
      int d0;
      int d1;
      int w;
      bus.req_valid  = 2'b11;   // held during reset: no ready may appear
      bus.req_wr     = '0;
      bus.req_wdata0 = '0;
      bus.req_wdata1 = '0;
      out_busy = 1'b0;
      in_full  = 1'b0;
      in_data  = '0;
      rdy_cnt  = '{0, 0};
      done_cnt = '{0, 0};
      reset    = 1'b1;
      @(posedge clk);
      apply_reset();
      bus.req_valid = 2'b00;
      @(posedge clk); #1;

      // Send success
      out_busy = 1'b0;
      do_req(1'b0, 1'b1, 64'd1204);
      // Receive success
      in_full = 1'b1;
      in_data = 64'd1312;
      do_req(1'b1, 1'b0, 64'd0);
      // Send poll timeout
      out_busy = 1'b1;
      do_req(1'b0, 1'b1, 64'hAAAA_0000_BBBB_1111);
      // Receive poll timeout
      in_full = 1'b0;
      do_req(1'b1, 1'b0, 64'd0);

      // Reset during a send XFER
      out_busy = 1'b0;
      r0 = rdy_cnt[0];
      bus.req_wr[0]  = 1'b1;
      bus.req_wdata0 = 64'h5555_5555;
      bus.req_valid[0] = 1'b1;
      wait_ready(1'b0, r0);
      bus.req_valid[0] = 1'b0;
      w = 0;
      do begin
         @(negedge clk); #1;
         w++;
      end while (!(bus.nicEn && bus.nicWrEn) && w < 10);
      check("xfer_reached", 128'(bus.nicEn && bus.nicWrEn), 128'(1));
      d0 = done_cnt[0] + done_cnt[1];
      apply_reset();
      repeat (5) @(posedge clk);
      #1;
      check("abort_no_done", 128'(done_cnt[0] + done_cnt[1] - d0), 128'(0));
      do_req(1'b0, 1'b1, 64'h6666_7777);

      // Withdrawal of requester 0 while requester 1 is busy
      in_full = 1'b1;
      in_data = 64'h3333_4444_5555_6666;
      r0 = rdy_cnt[1];
      d1 = done_cnt[1];
      bus.req_wr[1] = 1'b0;
      bus.req_valid[1] = 1'b1;
      wait_ready(1'b1, r0);
      bus.req_valid[1] = 1'b0;
      r0 = rdy_cnt[0];
      d0 = done_cnt[0];
      bus.req_valid[0] = 1'b1;
      @(posedge clk); #1;
      bus.req_valid[0] = 1'b0;
      wait_done(1'b1, d1);
      repeat (5) @(posedge clk);
      #1;
      check("wd_no_ready", 128'(rdy_cnt[0] - r0), 128'(0));
      check("wd_no_done", 128'(done_cnt[0] - d0), 128'(0));

      // Contention from reset: expect grants 0,1,0,1
      apply_reset();
      grant_log.delete();
      out_busy = 1'b0;
      in_full  = 1'b1;
      in_data  = 64'h0BAD_F00D_1234_5678;
      bus.req_wr     = 2'b01;
      bus.req_wdata0 = 64'h1111;
      bus.req_wdata1 = 64'h2222;
      d0 = done_cnt[0] + done_cnt[1];
      bus.req_valid = 2'b11;
      w = 0;
      while ((done_cnt[0] + done_cnt[1] - d0) < 4 && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      bus.req_valid = 2'b00;
      repeat (4) @(posedge clk);
      #1;
      check("cont_count", 128'(grant_log.size()), 128'(4));
      for (int k = 0; k < 4; k++) begin
         if (k < grant_log.size())
            check("cont_order", 128'(grant_log[k]), 128'(k % 2));
      end
      check("sb_empty", 128'(sb.size()), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      n_mis++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $fatal(1, "watchdog");
   end

endmodule
